// File: rtl/comp_seq.sv
// comp_seq: multi-beat unsigned magnitude comparator with cascade seed.
// Operands arrive MS beat first. The first beat that differs decides the
// result, and later beats are only counted. The result is held until the
// consumer accepts it.
module comp_seq #(
  parameter  int W     = 8,
  parameter  int N_MAX = 16,
  localparam int CW    = $clog2(N_MAX + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic          EQ_in,
  input  logic          GT_in,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          EQ,
  output logic          GT,
  output logic          LT,
  output logic [CW-1:0] beats,
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_MAX = CW'(N_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  // Running comparison. An all-zero value means undecided with no beats
  // counted, which is also the reset and cleared value.
  typedef struct packed {
    logic          decided;
    logic          gt;
    logic [CW-1:0] cnt;
    logic          ovf;
  } acc_t;

  state_t        state, state_d;
  acc_t          acc, acc_d;
  logic          accept;
  logic          seed_dec, seed_gt;
  logic [CW-1:0] base_cnt;
  logic          base_ovf;

  // in_ready is gated by reset_n so that no beat appears accepted while
  // reset is asserted.
  assign in_ready  = reset_n && (state != S_RESULT);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_RESULT);
  assign EQ        = !acc.decided;
  assign GT        = acc.decided && acc.gt;
  assign LT        = acc.decided && !acc.gt;
  assign beats     = acc.cnt;
  assign ovf       = acc.ovf;

  // State and accumulator registers; reset discards any partial or held result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      acc   <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
    end
  end

  // Next-state and accumulator update. A first beat starts from the cascade
  // seed and a zero count. Later beats start from the held accumulator.
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    seed_dec = acc.decided;
    seed_gt  = acc.gt;
    base_cnt = acc.cnt;
    base_ovf = acc.ovf;
    if (state == S_IDLE) begin
      seed_dec = !EQ_in;
      seed_gt  = EQ_in ? 1'b0 : GT_in;
      base_cnt = '0;
      base_ovf = 1'b0;
    end
    case (state)
      S_IDLE, S_RUN: begin
        if (accept) begin
          acc_d.decided = seed_dec;
          acc_d.gt      = seed_gt;
          if (!seed_dec && (A != B)) begin
            acc_d.decided = 1'b1;
            acc_d.gt      = (A > B);
          end
          // The count saturates, and a beat arriving at saturation flags overflow.
          if (base_cnt == CNT_MAX) begin
            acc_d.cnt = base_cnt;
            acc_d.ovf = 1'b1;
          end else begin
            acc_d.cnt = base_cnt + 1'b1;
            acc_d.ovf = base_ovf;
          end
          state_d = in_last ? S_RESULT : S_RUN;
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_comp_seq.sv
// Directed bench for comp_seq (W=8, N_MAX=4 so overflow is reachable).
module tb_comp_seq;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] A, B;
  logic       EQ_in, GT_in, in_valid, in_last, out_ready;
  logic       in_ready, out_valid, EQ, GT, LT, ovf;
  logic [2:0] beats;
  logic [7:0] obs;
  int vectors = 0;
  int errors  = 0;

  comp_seq #(.W(8), .N_MAX(4)) dut (
    .clock(clock), .reset_n(reset_n), .A(A), .B(B), .EQ_in(EQ_in), .GT_in(GT_in),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .EQ(EQ), .GT(GT), .LT(LT),
    .beats(beats), .ovf(ovf)
  );

  always #5 clock = ~clock;

  // Observed word: {out_valid, EQ, GT, LT, beats[2:0], ovf}
  assign obs = {out_valid, EQ, GT, LT, beats, ovf};

  // Present one beat for one clock. Inputs change 1 time unit after the edge.
  task automatic beat(input logic [7:0] a, input logic [7:0] b,
                      input logic eqi, input logic gti, input logic last);
    A = a; B = b; EQ_in = eqi; GT_in = gti; in_last = last; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    A = 8'h00; B = 8'h00; EQ_in = 1'b1; GT_in = 1'b0;
    #12;
    vectors++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, 8'b0100_0000); end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_equal;
    beat(8'h12, 8'h12, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== 8'b0100_0010) begin errors++; $display("FAIL eq_running got %b want %b", obs, 8'b0100_0010); end
    beat(8'h34, 8'h34, 1'b1, 1'b0, 1'b0);
    beat(8'h56, 8'h56, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (obs !== 8'b1100_0110) begin errors++; $display("FAIL eq_result got %b want %b", obs, 8'b1100_0110); end
    @(posedge clock); #1;
    vectors++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL eq_cleared got %b want %b", obs, 8'b0100_0000); end
  endtask

  task automatic test_gt_msb;
    beat(8'h10, 8'h0F, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== 8'b0010_0010) begin errors++; $display("FAIL gt_after_beat1 got %b want %b", obs, 8'b0010_0010); end
    beat(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (obs !== 8'b1010_0100) begin errors++; $display("FAIL gt_result got %b want %b", obs, 8'b1010_0100); end
    @(posedge clock); #1;
  endtask

  task automatic test_seed;
    beat(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (obs !== 8'b1010_0010) begin errors++; $display("FAIL seed_gt got %b want %b", obs, 8'b1010_0010); end
    @(posedge clock); #1;
    // Seed "not equal, not greater" gives LT even for equal operands.
    beat(8'h44, 8'h44, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (obs !== 8'b1001_0010) begin errors++; $display("FAIL seed_lt got %b want %b", obs, 8'b1001_0010); end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(8'h05, 8'h03, 1'b1, 1'b0, 1'b1);
    // Offer a conflicting beat that must not be taken while the result is held.
    A = 8'h00; B = 8'hFF; EQ_in = 1'b1; GT_in = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (obs !== 8'b1010_0010) begin errors++; $display("FAIL bp_hold[%0d] got %b want %b", i, obs, 8'b1010_0010); end
      vectors++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL bp_released got %b want %b", obs, 8'b0100_0000); end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again got %b want 1", in_ready); end
    @(posedge clock); #1;
    in_valid = 1'b0;
    vectors++;
    if (obs !== 8'b1001_0010) begin errors++; $display("FAIL bp_next_beat got %b want %b", obs, 8'b1001_0010); end
    @(posedge clock); #1;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) beat(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== 8'b0100_1000) begin errors++; $display("FAIL ovf_at_max got %b want %b", obs, 8'b0100_1000); end
    beat(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== 8'b0100_1001) begin errors++; $display("FAIL ovf_set got %b want %b", obs, 8'b0100_1001); end
    beat(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (obs !== 8'b1100_1001) begin errors++; $display("FAIL ovf_result got %b want %b", obs, 8'b1100_1001); end
    @(posedge clock); #1;
    vectors++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL ovf_cleared got %b want %b", obs, 8'b0100_0000); end
  endtask

  task automatic test_reset_mid;
    beat(8'h12, 8'h12, 1'b1, 1'b0, 1'b0);
    beat(8'h35, 8'h34, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== 8'b0010_0100) begin errors++; $display("FAIL mid_before_reset got %b want %b", obs, 8'b0010_0100); end
    reset_n = 1'b0;
    #2;
    vectors++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL mid_async_reset got %b want %b", obs, 8'b0100_0000); end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready got %b want 0", in_ready); end
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL mid_no_result got %b want %b", obs, 8'b0100_0000); end
    beat(8'h01, 8'h02, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (obs !== 8'b1001_0010) begin errors++; $display("FAIL mid_fresh_lt got %b want %b", obs, 8'b1001_0010); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset;
    test_equal;
    test_gt_msb;
    test_seed;
    test_backpressure;
    test_overflow;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 Parameter W, default 8, bit width of one operand beat.
REQ-002 Parameter N_MAX, default 16, maximum beats per comparison before overflow is flagged.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous reset, active-low.
REQ-005 A  input  W  operand-A beat, most-significant beat first.
REQ-006 B  input  W  operand-B beat, most-significant beat first.
REQ-007 EQ_in  input  1  cascade seed "higher-order bits equal"; sampled only on the first beat of a comparison.
REQ-008 GT_in  input  1  cascade seed "higher-order A greater"; sampled only on the first beat.
REQ-009 in_valid  input  1  A/B/in_last/seed valid this cycle.
REQ-010 in_last  input  1  marks the final (least-significant) beat.
REQ-011 in_ready  output  1  block can accept a beat this cycle.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 EQ  output  1  A == B over all beats, seed included.
REQ-015 GT  output  1  A > B (unsigned) over all beats, seed included.
REQ-016 LT  output  1  A < B; exactly one of EQ/GT/LT SHALL be high while out_valid=1.
REQ-017 beats  output  clog2(N_MAX+1)  number of beats accepted in the reported comparison, saturating at N_MAX.
REQ-018 ovf  output  1  more than N_MAX beats were accepted in the reported comparison.

Function
REQ-019 The FSM SHALL have three states: IDLE (no beat yet), RUN (at least one beat accepted, no in_last yet), RESULT (result held).
REQ-020 A beat is accepted when in_valid && in_ready at a rising edge; in_ready SHALL be 1 in IDLE and RUN and 0 in RESULT.
REQ-021 On a first beat accepted in IDLE, the accumulator SHALL be seeded from EQ_in/GT_in: EQ_in=1 -> undecided (GT_in ignored); EQ_in=0 -> decided, with GT=GT_in.
REQ-022 On each accepted beat while undecided: A>B -> decided GT; A<B -> decided LT; A==B -> remains undecided.
REQ-023 Once decided, later beats SHALL be consumed and counted but SHALL NOT change the decision.
REQ-024 Accepted beat with in_last=0: IDLE->RUN, RUN->RUN. Accepted beat with in_last=1, from IDLE or RUN: ->RESULT. A single-beat comparison (first beat with in_last=1) SHALL be legal.
REQ-025 Latency: out_valid SHALL rise on the clock edge that accepts the in_last beat, so it is visible in the following cycle; undecided at that edge -> EQ=1.
REQ-026 In RESULT, EQ/GT/LT/beats/ovf SHALL be held stable until out_valid && out_ready; on that edge out_valid->0, state->IDLE and the accumulator is cleared.
REQ-027 No result/new-beat overlap: a beat offered in the same cycle that the result is accepted SHALL NOT be accepted, because in_ready=0 in RESULT.
REQ-028 The beat counter SHALL increment per accepted beat and saturate at N_MAX; accepting a beat while the count is already N_MAX SHALL set ovf, which stays set until the result is accepted.
REQ-029 ovf SHALL NOT alter EQ/GT/LT; the comparison SHALL continue until in_last.
REQ-030 In IDLE and RUN, out_valid SHALL be 0 and EQ/GT/LT SHALL show the running accumulator (EQ=1 when undecided).
REQ-031 Inputs other than out_ready SHALL be ignored when in_valid=0.

Reset
REQ-032 reset_n=0 SHALL immediately force: state IDLE, out_valid=0, EQ=1, GT=0, LT=0, beats=0, ovf=0.
REQ-033 in_ready SHALL be 0 while reset_n=0 and 1 in the first cycle after deassertion.
REQ-034 Reset asserted mid-RUN or in RESULT SHALL discard the partial or held comparison; no result SHALL be emitted after reset.

Verification
REQ-035 Three beats A=12,34,56 and B=12,34,56 (hex), seed EQ_in=1, out_ready=1 -> out_valid one cycle after the last beat, EQ=1, GT=0, LT=0, beats=3, ovf=0.
REQ-036 Beats A=10,00 and B=0F,FF (hex), seed EQ_in=1 -> GT=1 (decided on beat 1; beat 2 has no effect), beats=2.
REQ-037 Single beat A=00, B=FF with seed EQ_in=0, GT_in=1 -> GT=1 (seed dominates), beats=1.
REQ-038 Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid held 1 -> in_ready=0, outputs stable for all 5 cycles, no beat accepted; out_ready=1 -> IDLE, next beat accepted the following cycle.
REQ-039 With N_MAX=4, send 6 equal beats, last on beat 6 -> beats=4, ovf=1, EQ=1.
REQ-040 reset_n pulsed low asynchronously mid-RUN after 2 of 3 beats -> outputs immediately at reset values; a fresh 1-beat compare A=01, B=02 -> LT=1, beats=1.
